dll_ack_nak_ctrl: RTL and testbench

Data-link-layer transmit-side controller that sits directly upstream of the replay buffer. It tracks the next transmit sequence number and the last acknowledged sequence (ACKD_SEQ), and validates incoming ACK/NAK DLLPs. It runs the replay timer and REPLAY_NUM counter and drives the replay buffer's `ack_nak`, `seq` and `tim_out` inputs. It also stalls TLP issue when the sequence window is exhausted and requests link retrain after repeated replays.

---
 rtl/dll_pkg.sv | 20 ++
 rtl/replay_timer.sv | 50 +++++
 rtl/dll_ack_nak_ctrl.sv | 155 +++++++++++++++
 tb/tb_dll_ack_nak_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dll_pkg.sv
// Shared DLL transmit-side definitions: ACK/NAK encodings and modulo
// sequence arithmetic used by the ACK/NAK controller.
package dll_pkg;

   localparam int SEQ_W = 12;

   localparam logic [1:0] DLLP_NONE = 2'b00;
   localparam logic [1:0] DLLP_ACK  = 2'b01;
   localparam logic [1:0] DLLP_NAK  = 2'b10;

   // (a - b) mod 2^w, for any sequence width up to 31 bits
   function automatic logic [31:0] seq_diff(
      input logic [31:0] a,
      input logic [31:0] b,
      input int          w
   );
      return (a - b) & ((32'd1 << w) - 32'd1);
   endfunction

endpackage

// File: rtl/replay_timer.sv
// Replay timer: counts while running, expires at TIMEOUT-1 and wraps to 0.
// expire is combinational so the controller can arbitrate it first.
module replay_timer #(
   parameter int TIMEOUT = 711,
   parameter int CW      = $clog2(TIMEOUT)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          hold,
   input  logic          clear,
   output logic [CW-1:0] cnt,
   output logic          expire
);

   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic          run_q, run_d;
   logic [CW-1:0] cnt_q, cnt_d;

   assign expire = run_q && !hold && (cnt_q == LAST);
   assign cnt    = cnt_q;

   always_comb begin
      run_d = run_q;
      cnt_d = cnt_q;
      if (clear) begin
         run_d = 1'b0;
         cnt_d = '0;
      end else if (start) begin
         run_d = 1'b1;
         cnt_d = '0;
      end else if (hold) begin
         cnt_d = '0;
      end else if (run_q) begin
         cnt_d = expire ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         run_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         run_q <= run_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/dll_ack_nak_ctrl.sv
// Transmit-side ACK/NAK controller: sequence tracking, DLLP validation,
// replay timer and REPLAY_NUM handling in front of the replay buffer.
module dll_ack_nak_ctrl #(
   parameter int SEQ_W          = 12,
   parameter int REPLAY_TIMEOUT = 711
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tlp_sent,
   input  logic             dllp_valid,
   input  logic [1:0]       dllp_type,
   input  logic [SEQ_W-1:0] dllp_seq,
   input  logic             replay_done,
   output logic [1:0]       ack_nak,
   output logic [SEQ_W-1:0] seq,
   output logic             tim_out,
   output logic [SEQ_W-1:0] next_tx_seq,
   output logic [SEQ_W-1:0] acked_seq,
   output logic [1:0]       replay_num,
   output logic             replaying,
   output logic             tx_stall,
   output logic             retrain_req,
   output logic             dllp_err
);

   import dll_pkg::*;

   localparam int              CW  = $clog2(REPLAY_TIMEOUT);
   localparam logic [SEQ_W-1:0] ONE = SEQ_W'(1);

   logic [SEQ_W-1:0] next_q, next_d;
   logic [SEQ_W-1:0] acked_q, acked_d;
   logic [SEQ_W-1:0] seq_q, seq_d;
   logic [1:0]       ack_nak_q, ack_nak_d;
   logic [1:0]       rnum_q, rnum_d;
   logic             tim_out_q, tim_out_d;
   logic             replaying_q, replaying_d;
   logic             stall_q, stall_d;
   logic             retrain_q, retrain_d;
   logic             err_q, err_d;

   logic             tlp_ok, is_ack, is_nak, in_err, progress;
   logic             nak_ok, exp_ok, trig, done_ok;
   logic             outst_q, outst_d;
   logic [SEQ_W-1:0] win, span;
   logic [1:0]       rbase;

   logic             tmr_start, tmr_clear, tmr_exp;
   logic [CW-1:0]    tmr_cnt;

   replay_timer #(
      .TIMEOUT (REPLAY_TIMEOUT),
      .CW      (CW)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .start  (tmr_start),
      .hold   (replaying_q),
      .clear  (tmr_clear),
      .cnt    (tmr_cnt),
      .expire (tmr_exp)
   );

   always_comb begin
      tlp_ok   = tlp_sent && !stall_q;
      is_ack   = dllp_valid && (dllp_type == DLLP_ACK);
      is_nak   = dllp_valid && (dllp_type == DLLP_NAK);
      win      = SEQ_W'(seq_diff(32'(next_q - ONE), 32'(dllp_seq), SEQ_W));
      in_err   = (is_ack || is_nak) && win[SEQ_W-1];
      progress = (is_ack || is_nak) && !in_err && (dllp_seq != acked_q);
      nak_ok   = is_nak && !in_err;
      // a progressing DLLP restarts the timer, so its expiry is moot
      exp_ok   = tmr_exp && !progress;
      trig     = nak_ok || exp_ok;
      done_ok  = replay_done && replaying_q;

      next_d   = tlp_ok ? next_q + ONE : next_q;
      acked_d  = progress ? dllp_seq : acked_q;
      outst_q  = acked_q != next_q - ONE;
      outst_d  = acked_d != next_d - ONE;

      rbase     = progress ? 2'd0 : rnum_q;
      rnum_d    = trig ? rbase + 2'd1 : rbase;
      retrain_d = trig && (rbase == 2'd3);

      replaying_d = trig ? 1'b1 : (done_ok ? 1'b0 : replaying_q);
      tim_out_d   = exp_ok;
      err_d       = in_err;

      ack_nak_d = DLLP_NONE;
      seq_d     = seq_q;
      if (nak_ok) begin
         ack_nak_d = DLLP_NAK;
         seq_d     = acked_d;
      end else if (is_ack && progress) begin
         ack_nak_d = DLLP_ACK;
         seq_d     = dllp_seq;
      end

      span    = SEQ_W'(seq_diff(32'(next_d), 32'(acked_d), SEQ_W));
      stall_d = span[SEQ_W-1] || replaying_d;

      tmr_clear = trig
               || (progress && !outst_d)
               || (done_ok && !outst_d);
      tmr_start = !tmr_clear
               && ((progress && outst_d)
                || (tlp_ok && !outst_q && !replaying_q)
                || done_ok);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         next_q      <= '0;
         acked_q     <= '1;
         seq_q       <= '0;
         ack_nak_q   <= DLLP_NONE;
         rnum_q      <= 2'd0;
         tim_out_q   <= 1'b0;
         replaying_q <= 1'b0;
         stall_q     <= 1'b0;
         retrain_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         next_q      <= next_d;
         acked_q     <= acked_d;
         seq_q       <= seq_d;
         ack_nak_q   <= ack_nak_d;
         rnum_q      <= rnum_d;
         tim_out_q   <= tim_out_d;
         replaying_q <= replaying_d;
         stall_q     <= stall_d;
         retrain_q   <= retrain_d;
         err_q       <= err_d;
      end
   end

   assign ack_nak     = ack_nak_q;
   assign seq         = seq_q;
   assign tim_out     = tim_out_q;
   assign next_tx_seq = next_q;
   assign acked_seq   = acked_q;
   assign replay_num  = rnum_q;
   assign replaying   = replaying_q;
   assign tx_stall    = stall_q;
   assign retrain_req = retrain_q;
   assign dllp_err    = err_q;

   a_no_tlp_in_stall: assert property (
      @(posedge clk) disable iff (!reset) !(tlp_sent && stall_q));

   a_tmr_range: assert property (
      @(posedge clk) disable iff (!reset) int'(tmr_cnt) < REPLAY_TIMEOUT);

endmodule

// File: tb/tb_dll_ack_nak_ctrl.sv
// Self-checking bench for dll_ack_nak_ctrl: vector table with a
// scoreboard queue, plus timer, window and wrap sequences.
module tb_dll_ack_nak_ctrl;

   import dll_pkg::*;

   localparam int SW = dll_pkg::SEQ_W;
   localparam int TO = 711;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          tlp_sent = 1'b0;
   logic          dllp_valid = 1'b0;
   logic [1:0]    dllp_type = 2'b00;
   logic [SW-1:0] dllp_seq = '0;
   logic          replay_done = 1'b0;
   logic [1:0]    ack_nak;
   logic [SW-1:0] seq;
   logic          tim_out;
   logic [SW-1:0] next_tx_seq;
   logic [SW-1:0] acked_seq;
   logic [1:0]    replay_num;
   logic          replaying;
   logic          tx_stall;
   logic          retrain_req;
   logic          dllp_err;

   always #5 clk = ~clk;

   dll_ack_nak_ctrl #(
      .SEQ_W          (SW),
      .REPLAY_TIMEOUT (TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .tlp_sent    (tlp_sent),
      .dllp_valid  (dllp_valid),
      .dllp_type   (dllp_type),
      .dllp_seq    (dllp_seq),
      .replay_done (replay_done),
      .ack_nak     (ack_nak),
      .seq         (seq),
      .tim_out     (tim_out),
      .next_tx_seq (next_tx_seq),
      .acked_seq   (acked_seq),
      .replay_num  (replay_num),
      .replaying   (replaying),
      .tx_stall    (tx_stall),
      .retrain_req (retrain_req),
      .dllp_err    (dllp_err)
   );

   typedef struct {
      logic          tlp;
      logic          vld;
      logic [1:0]    typ;
      logic [SW-1:0] dseq;
      logic          rdone;
      logic [SW-1:0] e_next;
      logic [SW-1:0] e_acked;
      logic [1:0]    e_an;
      logic          e_seq_chk;
      logic [SW-1:0] e_seq;
      logic          e_err;
      logic [1:0]    e_rnum;
      logic          e_rep;
      logic          e_stall;
   } vec_t;

   vec_t tbl[18];
   vec_t exp_q[$];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      tlp_sent    = 1'b0;
      dllp_valid  = 1'b0;
      dllp_type   = 2'b00;
      dllp_seq    = '0;
      replay_done = 1'b0;
   endtask

   task automatic do_reset();
      idle_in();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic drive_dllp(input logic [1:0] t, input logic [SW-1:0] s);
      dllp_valid = 1'b1;
      dllp_type  = t;
      dllp_seq   = s;
   endtask

   task automatic wait_tmo(output int lat);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!tim_out && lat < 2000);
   endtask

   function automatic vec_t mk(
      input logic tlp, input logic vld, input logic [1:0] typ,
      input int dseq, input logic rdone,
      input int nx, input int ak, input logic [1:0] an, input int sq,
      input logic er, input logic [1:0] rn, input logic rp,
      input logic st);
      vec_t v;
      v.tlp       = tlp;
      v.vld       = vld;
      v.typ       = typ;
      v.dseq      = SW'(dseq);
      v.rdone     = rdone;
      v.e_next    = SW'(nx);
      v.e_acked   = SW'(ak);
      v.e_an      = an;
      v.e_seq_chk = (sq >= 0);
      v.e_seq     = SW'(sq);
      v.e_err     = er;
      v.e_rnum    = rn;
      v.e_rep     = rp;
      v.e_stall   = st;
      return v;
   endfunction

   initial begin
      int   lat;
      int   sent;
      int   first;
      int   n;
      int   seen;
      vec_t e;

      //         tlp v typ       dseq rd next acked an        seq err rn rp st
      tbl[0]  = mk(1, 0, 2'b00,     0, 0, 1, 4095, DLLP_NONE, -1, 0, 0, 0, 0);
      tbl[1]  = mk(1, 0, 2'b00,     0, 0, 2, 4095, DLLP_NONE, -1, 0, 0, 0, 0);
      tbl[2]  = mk(1, 0, 2'b00,     0, 0, 3, 4095, DLLP_NONE, -1, 0, 0, 0, 0);
      tbl[3]  = mk(0, 1, DLLP_ACK,  1, 0, 3,    1, DLLP_ACK,   1, 0, 0, 0, 0);
      tbl[4]  = mk(0, 1, DLLP_ACK,  2, 0, 3,    2, DLLP_ACK,   2, 0, 0, 0, 0);
      tbl[5]  = mk(0, 1, DLLP_ACK,  2, 0, 3,    2, DLLP_NONE, -1, 0, 0, 0, 0);
      tbl[6]  = mk(1, 0, 2'b00,     0, 0, 4,    2, DLLP_NONE, -1, 0, 0, 0, 0);
      tbl[7]  = mk(0, 1, DLLP_NAK,  3, 0, 4,    3, DLLP_NAK,   3, 0, 1, 1, 1);
      tbl[8]  = mk(0, 0, 2'b00,     0, 1, 4,    3, DLLP_NONE, -1, 0, 1, 0, 0);
      tbl[9]  = mk(1, 0, 2'b00,     0, 0, 5,    3, DLLP_NONE, -1, 0, 1, 0, 0);
      tbl[10] = mk(0, 1, DLLP_ACK, 2000,0, 5,    3, DLLP_NONE, -1, 1, 1, 0, 0);
      tbl[11] = mk(0, 1, DLLP_ACK,  3, 0, 5,    3, DLLP_NONE, -1, 0, 1, 0, 0);
      tbl[12] = mk(0, 1, DLLP_NAK,  4, 0, 5,    4, DLLP_NAK,   4, 0, 1, 1, 1);
      tbl[13] = mk(0, 0, 2'b00,     0, 1, 5,    4, DLLP_NONE, -1, 0, 1, 0, 0);
      tbl[14] = mk(0, 1, 2'b11,     4, 0, 5,    4, DLLP_NONE, -1, 0, 1, 0, 0);
      tbl[15] = mk(0, 1, DLLP_NAK,  4, 0, 5,    4, DLLP_NAK,   4, 0, 2, 1, 1);
      tbl[16] = mk(0, 0, 2'b00,     0, 1, 5,    4, DLLP_NONE, -1, 0, 2, 0, 0);
      tbl[17] = mk(0, 0, 2'b00,     0, 1, 5,    4, DLLP_NONE, -1, 0, 2, 0, 0);

      do_reset();
      chk("rst_next", next_tx_seq, 0);
      chk("rst_acked", acked_seq, 4095);
      chk("rst_rnum", replay_num, 0);
      chk("rst_replaying", replaying, 0);
      chk("rst_stall", tx_stall, 0);
      chk("rst_ack_nak", ack_nak, 0);
      chk("rst_seq", seq, 0);
      chk("rst_tim_out", tim_out, 0);
      chk("rst_retrain", retrain_req, 0);
      chk("rst_err", dllp_err, 0);

      foreach (tbl[i]) begin
         exp_q.push_back(tbl[i]);
         idle_in();
         tlp_sent    = tbl[i].tlp;
         dllp_valid  = tbl[i].vld;
         dllp_type   = tbl[i].typ;
         dllp_seq    = tbl[i].dseq;
         replay_done = tbl[i].rdone;
         tick();
         e = exp_q.pop_front();
         chk($sformatf("v%0d_next", i), next_tx_seq, e.e_next);
         chk($sformatf("v%0d_acked", i), acked_seq, e.e_acked);
         chk($sformatf("v%0d_ack_nak", i), ack_nak, e.e_an);
         if (e.e_seq_chk) chk($sformatf("v%0d_seq", i), seq, e.e_seq);
         chk($sformatf("v%0d_err", i), dllp_err, e.e_err);
         chk($sformatf("v%0d_rnum", i), replay_num, e.e_rnum);
         chk($sformatf("v%0d_replaying", i), replaying, e.e_rep);
         chk($sformatf("v%0d_stall", i), tx_stall, e.e_stall);
         chk($sformatf("v%0d_tim_out", i), tim_out, 0);
      end
      idle_in();

      // nothing outstanding: timer must stay stopped
      seen = 0;
      repeat (800) begin
         tick();
         if (tim_out) seen++;
      end
      chk("idle_no_timeout", seen, 0);

      // four consecutive timeouts without progress
      do_reset();
      tlp_sent = 1'b1;
      tick();
      idle_in();
      for (int k = 1; k <= 4; k++) begin
         wait_tmo(lat);
         chk($sformatf("tmo%0d_latency", k), lat, TO);
         chk($sformatf("tmo%0d_rnum", k), replay_num, k % 4);
         chk($sformatf("tmo%0d_retrain", k), retrain_req, (k == 4));
         tick();
         chk($sformatf("tmo%0d_replaying", k), replaying, 1);
         chk($sformatf("tmo%0d_pulse_end", k), tim_out, 0);
         chk($sformatf("tmo%0d_retrain_end", k), retrain_req, 0);
         chk($sformatf("tmo%0d_stall", k), tx_stall, 1);
         seen = 0;
         repeat (50) begin
            tick();
            if (tim_out) seen++;
         end
         chk($sformatf("tmo%0d_held", k), seen, 0);
         replay_done = 1'b1;
         tick();
         idle_in();
         chk($sformatf("tmo%0d_done", k), replaying, 0);
      end

      // NAK coinciding with expiry counts as one replay
      do_reset();
      tlp_sent = 1'b1;
      tick();
      idle_in();
      repeat (TO - 1) tick();
      drive_dllp(DLLP_NAK, SW'(4095));
      tick();
      idle_in();
      chk("nakexp_tim_out", tim_out, 1);
      chk("nakexp_rnum", replay_num, 1);
      chk("nakexp_ack_nak", ack_nak, DLLP_NAK);
      chk("nakexp_seq", seq, 4095);
      chk("nakexp_replaying", replaying, 1);

      // progressing ACK suppresses a same-cycle expiry and restarts timer
      do_reset();
      tlp_sent = 1'b1;
      tick();
      tick();
      idle_in();
      repeat (TO - 2) tick();
      drive_dllp(DLLP_ACK, SW'(0));
      tick();
      idle_in();
      chk("acksup_tim_out", tim_out, 0);
      chk("acksup_rnum", replay_num, 0);
      chk("acksup_ack_nak", ack_nak, DLLP_ACK);
      chk("acksup_acked", acked_seq, 0);
      wait_tmo(lat);
      chk("acksup_restart", lat, TO);
      chk("acksup_rnum2", replay_num, 1);

      // reset while replaying
      tick();
      chk("midrst_pre", replaying, 1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("midrst_replaying", replaying, 0);
      chk("midrst_next", next_tx_seq, 0);
      chk("midrst_acked", acked_seq, 4095);
      chk("midrst_rnum", replay_num, 0);
      chk("midrst_stall", tx_stall, 0);

      // fill the window without ACKs
      sent  = 0;
      first = -1;
      n     = 0;
      while (sent < 2047 && n < 20000) begin
         idle_in();
         if (replaying) replay_done = 1'b1;
         else if (!tx_stall) begin
            tlp_sent = 1'b1;
            sent++;
         end
         tick();
         n++;
         if (first < 0 && tx_stall && !replaying) first = sent;
      end
      idle_in();
      if (replaying) begin
         replay_done = 1'b1;
         tick();
         idle_in();
      end
      if (first < 0 && tx_stall && !replaying) first = sent;
      chk("win_sent", sent, 2047);
      chk("win_first_stall", first, 2047);
      chk("win_next", next_tx_seq, 2047);
      chk("win_stall", tx_stall, 1);
      drive_dllp(DLLP_ACK, SW'(0));
      tick();
      idle_in();
      chk("win_ack_an", ack_nak, DLLP_ACK);
      chk("win_ack_acked", acked_seq, 0);
      chk("win_ack_stall", tx_stall, 0);

      // stream with ACKs up to the wrap point
      n = 0;
      while (next_tx_seq != SW'(4095) && n < 5000) begin
         idle_in();
         if (replaying) replay_done = 1'b1;
         else begin
            tlp_sent = !tx_stall;
            drive_dllp(DLLP_ACK, SW'(next_tx_seq - SW'(1)));
         end
         tick();
         n++;
      end
      chk("wrap_reach", next_tx_seq, 4095);
      idle_in();
      tlp_sent = 1'b1;
      drive_dllp(DLLP_ACK, SW'(4094));
      tick();
      chk("wrap0_next", next_tx_seq, 0);
      chk("wrap0_acked", acked_seq, 4094);
      chk("wrap0_err", dllp_err, 0);
      idle_in();
      tlp_sent = 1'b1;
      drive_dllp(DLLP_ACK, SW'(4095));
      tick();
      idle_in();
      chk("wrap1_next", next_tx_seq, 1);
      chk("wrap1_acked", acked_seq, 4095);
      chk("wrap1_ack_nak", ack_nak, DLLP_ACK);
      chk("wrap1_seq", seq, 4095);
      chk("wrap1_err", dllp_err, 0);
      chk("wrap1_stall", tx_stall, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
